// File: rtl/iq_fifo_writer.sv
// Writer end of the I/Q sample FIFO.
// Each accepted pair is written as two back-to-back bytes, I then Q.
module iq_fifo_writer #(
    parameter int FIFO_DEPTH  = 256,
    parameter int USEDW_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_i,
    input  logic [7:0]             s_q,
    input  logic                   fifo_full,
    input  logic [USEDW_WIDTH-1:0] fifo_usedw,
    output logic                   fifo_wr,
    output logic [7:0]             fifo_data_in,
    output logic [15:0]            pairs_written,
    output logic                   overflow_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_I    = 2'b10
    } state_t;

    // Margin of 4: an uncounted Q byte, the new pair, and one byte of slack.
    localparam logic [USEDW_WIDTH-1:0] ROOM_MAX = USEDW_WIDTH'(FIFO_DEPTH - 4);

    state_t      state;
    state_t      state_nxt;
    logic        wr_nxt;
    logic [7:0]  data_nxt;
    logic [7:0]  q_hold;
    logic [7:0]  q_hold_nxt;
    logic [15:0] cnt_nxt;
    logic        room;

    // usedw wraps to 0 when full, so fifo_full must gate the level test.
    assign room    = !fifo_full && (fifo_usedw <= ROOM_MAX);
    assign s_ready = enable && room && (state == S_IDLE);

    // Next-state and next-output decode; Q always follows I unconditionally.
    always_comb begin
        state_nxt  = state;
        wr_nxt     = 1'b0;
        data_nxt   = fifo_data_in;
        q_hold_nxt = q_hold;
        cnt_nxt    = pairs_written;
        case (state)
            S_IDLE: begin
                if (s_valid && s_ready) begin
                    wr_nxt     = 1'b1;
                    data_nxt   = s_i;
                    q_hold_nxt = s_q;
                    state_nxt  = S_I;
                end
            end
            S_I: begin
                wr_nxt    = 1'b1;
                data_nxt  = q_hold;
                cnt_nxt   = pairs_written + 16'd1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered write port; overflow flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            fifo_wr       <= 1'b0;
            fifo_data_in  <= 8'd0;
            q_hold        <= 8'd0;
            pairs_written <= 16'd0;
            overflow_err  <= 1'b0;
        end else begin
            state         <= state_nxt;
            fifo_wr       <= wr_nxt;
            fifo_data_in  <= data_nxt;
            q_hold        <= q_hold_nxt;
            pairs_written <= cnt_nxt;
            overflow_err  <= overflow_err | (fifo_wr & fifo_full);
        end
    end

endmodule

// File: tb/tb_iq_fifo_writer.sv
// Self-checking bench for iq_fifo_writer.
// A byte-queue FIFO model and a pending-byte model supply every expected value.
module tb_iq_fifo_writer;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_i;
    logic [7:0]  s_q;
    logic        fifo_full;
    logic [7:0]  fifo_usedw;
    logic        fifo_wr;
    logic [7:0]  fifo_data_in;
    logic [15:0] pairs_written;
    logic        overflow_err;

    iq_fifo_writer #(
        .FIFO_DEPTH (DEPTH),
        .USEDW_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .fifo_full    (fifo_full),
        .fifo_usedw   (fifo_usedw),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .pairs_written(pairs_written),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fq[$];
    logic [7:0]  pend[$];
    int          exp_pairs;
    logic        exp_wr;
    logic [7:0]  exp_data;
    logic        exp_ovf;
    bit          rd_en;
    bit          ovr;
    logic        ovr_full;
    logic [7:0]  ovr_usedw;
    bit          last_hs;
    int          hs_total;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_env();
        if (ovr) begin
            fifo_full  = ovr_full;
            fifo_usedw = ovr_usedw;
        end else begin
            fifo_full  = (fq.size() == DEPTH);
            fifo_usedw = 8'(fq.size());
        end
    endtask

    // One clock: check s_ready before the edge, outputs after it.
    task automatic step();
        bit         exp_ready;
        bit         hs;
        logic       wr_now;
        logic [7:0] d_now;
        logic       full_now;
        logic [7:0] si;
        logic [7:0] sq;
        @(negedge clk);
        exp_ready = enable && !fifo_full && (int'(fifo_usedw) <= DEPTH - 4)
                    && (pend.size() == 0);
        if (!rst) chk("s_ready", 32'(s_ready), 32'(exp_ready));
        hs       = !rst && s_valid && exp_ready;
        wr_now   = fifo_wr;
        d_now    = fifo_data_in;
        full_now = fifo_full;
        si       = s_i;
        sq       = s_q;
        @(posedge clk);
        #1;
        last_hs = hs;
        if (rst) begin
            pend.delete();
            fq.delete();
            exp_pairs = 0;
            exp_wr    = 1'b0;
            exp_data  = 8'd0;
            exp_ovf   = 1'b0;
        end else begin
            if (wr_now && full_now) exp_ovf = 1'b1;
            if (pend.size() != 0) begin
                exp_wr    = 1'b1;
                exp_data  = pend.pop_front();
                exp_pairs = (exp_pairs + 1) % 65536;
            end else if (hs) begin
                exp_wr   = 1'b1;
                exp_data = si;
                pend.push_back(sq);
                hs_total++;
            end else begin
                exp_wr = 1'b0;
            end
            if (wr_now && fq.size() < DEPTH) fq.push_back(d_now);
            if (rd_en && fq.size() > 0) void'(fq.pop_front());
        end
        chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(exp_data));
        chk("pairs_written", 32'(pairs_written), 32'(exp_pairs));
        chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
        drive_env();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; s_valid = 1'b0;
        s_i = 8'd0; s_q = 8'd0; rd_en = 1'b1; ovr = 1'b0;
        ovr_full = 1'b0; ovr_usedw = 8'd0; hs_total = 0;
        exp_pairs = 0; exp_wr = 1'b0; exp_data = 8'd0; exp_ovf = 1'b0;
        drive_env();

        // Reset state and a single pair 12/34.
        do_reset();
        chk("reset_wr", 32'(fifo_wr), 32'd0);
        chk("reset_pairs", 32'(pairs_written), 32'd0);
        s_valid = 1'b1; s_i = 8'h12; s_q = 8'h34;
        step();
        s_valid = 1'b0;
        chk("t1_i", {fifo_wr, fifo_data_in}, {1'b1, 8'h12});
        step();
        chk("t1_q", {fifo_wr, fifo_data_in}, {1'b1, 8'h34});
        step();
        chk("t1_pairs", 32'(pairs_written), 32'd1);

        // Ten back-to-back pairs with a fast reader.
        do_reset();
        s_valid = 1'b1; s_i = 8'h00; s_q = 8'h80;
        for (int n = 0; n < 10;) begin
            step();
            if (last_hs) begin
                n++;
                s_i = s_i + 8'd1;
                s_q = s_q + 8'd1;
                if (n == 10) s_valid = 1'b0;
            end
        end
        step();
        step();
        chk("t2_pairs", 32'(pairs_written), 32'd10);

        // No reads, continuous s_valid: fill stops at 254 bytes.
        rd_en = 1'b0;
        do_reset();
        s_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            s_i = 8'($urandom);
            s_q = 8'($urandom);
            step();
        end
        chk("t3_fill", 32'(fq.size()), 32'd254);
        chk("t3_even", 32'(fq.size() % 2), 32'd0);
        chk("t3_ovf", 32'(overflow_err), 32'd0);
        chk("t3_ready", 32'(s_ready), 32'd0);

        // Full with usedw wrapped to 0.
        s_valid = 1'b0;
        do_reset();
        ovr = 1'b1; ovr_full = 1'b1; ovr_usedw = 8'd0;
        drive_env();
        s_valid = 1'b1;
        for (int n = 0; n < 4; n++) step();
        chk("t4_ready", 32'(s_ready), 32'd0);
        ovr = 1'b0;
        s_valid = 1'b0;
        rd_en = 1'b1;

        // enable dropped right after a handshake.
        do_reset();
        s_valid = 1'b1; s_i = 8'hA5; s_q = 8'h5A;
        step();
        enable = 1'b0;
        step();
        chk("t5_q", {fifo_wr, fifo_data_in}, {1'b1, 8'h5A});
        step();
        step();
        chk("t5_ready", 32'(s_ready), 32'd0);
        chk("t5_pairs", 32'(pairs_written), 32'd1);
        enable = 1'b1;
        s_valid = 1'b0;

        // Reset while I is on the bus abandons Q.
        do_reset();
        s_valid = 1'b1; s_i = 8'h77; s_q = 8'h99;
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_wr", 32'(fifo_wr), 32'd0);
        chk("t6_pairs", 32'(pairs_written), 32'd0);
        step();
        chk("t6_noq", 32'(fifo_wr), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            enable  = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            rd_en   = ($urandom_range(0, 9) < 4);
            s_i     = 8'($urandom);
            s_q     = 8'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
